// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
//   fwd_sel_e  : E-stage operand mux select (register file, W result, M ALU result)
//   hz_state_e : controller state (RUN, MEMWAIT)
//   REG_PC     : architectural PC register index; never a forwarding source
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_e;

  localparam int unsigned REG_PC = 15;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for a single E-stage source operand.
//   ra_i          : E-stage source register address
//   rd_m_i        : M-stage destination, reg_write_m_i its write enable
//   rd_w_i        : W-stage destination, reg_write_w_i its write enable
//   sel_c_o       : combinational mux select; M wins over W, R15 never forwards
module fwd_sel
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 4
) (
  input  logic [REG_AW-1:0] ra_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              reg_write_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_w_i,
  output fwd_sel_e          sel_c_o
);

  // Priority compare: youngest producer (M) first.
  always_comb begin
    sel_c_o = FWD_RF;
    if (ra_i != REG_AW'(REG_PC)) begin
      if (reg_write_m_i && (ra_i == rd_m_i)) begin
        sel_c_o = FWD_MEM;
      end else if (reg_write_w_i && (ra_i == rd_w_i)) begin
        sel_c_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage F/D/E/M/W pipeline.
// Tracks NSRC source operands per instruction, a variable-latency data-memory
// handshake (MEMWAIT) and a count of PC-writing instructions in flight.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   raD / raE             : D/E source register addresses, operand i at [i*REG_AW +: REG_AW]
//   rdE/RegWriteE/MemtoRegE, rdM/RegWriteM, rdW/RegWriteW : stage destinations
//   MemReqM / MemReadyM   : data-memory request and completion in M
//   PCSrcD / PCSrcW       : PC-writing instruction in D / retiring in W
//   BranchTakenE          : branch resolved taken in E
//   forwardE              : per-operand E mux select (2 bits each)
//   Stall{F,D,E,M}, Flush{D,E,W} : pipeline register controls
//   pcw_pending           : PC writes in flight (registered counter)
// Optional: define PIPE_HAZARD_PERF_EN to add stall_cycles / flush_cycles counters.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned NSRC    = 3,
  parameter int unsigned PCW_MAX = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NSRC*REG_AW-1:0]       raD,
  input  logic [NSRC*REG_AW-1:0]       raE,
  input  logic [REG_AW-1:0]            rdE,
  input  logic                         RegWriteE,
  input  logic                         MemtoRegE,
  input  logic [REG_AW-1:0]            rdM,
  input  logic                         RegWriteM,
  input  logic                         MemReqM,
  input  logic                         MemReadyM,
  input  logic [REG_AW-1:0]            rdW,
  input  logic                         RegWriteW,
  input  logic                         PCSrcD,
  input  logic                         PCSrcW,
  input  logic                         BranchTakenE,
  output logic [NSRC*2-1:0]            forwardE,
  output logic                         StallF,
  output logic                         StallD,
  output logic                         StallE,
  output logic                         StallM,
  output logic                         FlushD,
  output logic                         FlushE,
  output logic                         FlushW,
  output logic [$clog2(PCW_MAX+1)-1:0] pcw_pending
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  flush_cycles
`endif
);

  localparam int unsigned CW = $clog2(PCW_MAX + 1);

  hz_state_e     state_q, state_d;
  logic [CW-1:0] pcw_cnt_q, pcw_cnt_d;
  logic          ldstall;
  logic          memwait;
  logic          pcw_busy;
  logic          pcw_inc;
  logic          pcw_dec;
  fwd_sel_e      fwd_c [NSRC];

  // One comparator/priority slice per source operand.
  for (genvar g = 0; g < NSRC; g++) begin : g_fwd
    fwd_sel #(
      .REG_AW(REG_AW)
    ) u_fwd_sel (
      .ra_i          (raE[g*REG_AW +: REG_AW]),
      .rd_m_i        (rdM),
      .reg_write_m_i (RegWriteM),
      .rd_w_i        (rdW),
      .reg_write_w_i (RegWriteW),
      .sel_c_o       (fwd_c[g])
    );
  end

  // Pack operand selects; reset forces the register-file path.
  always_comb begin
    forwardE = '0;
    if (!reset) begin
      for (int i = 0; i < int'(NSRC); i++) begin
        forwardE[i*2 +: 2] = fwd_c[i];
      end
    end
  end

  // Load-use hazard on any D-stage source operand.
  always_comb begin
    ldstall = 1'b0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (raD[i*REG_AW +: REG_AW] == rdE) begin
        ldstall = 1'b1;
      end
    end
    ldstall = ldstall && MemtoRegE && RegWriteE;
  end

  assign pcw_busy = (pcw_cnt_q != '0);

  // Next state, stall/flush decode and PC-write counter update.
  always_comb begin
    state_d   = state_q;
    memwait   = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    pcw_cnt_d = pcw_cnt_q;

    // The cycle MemReadyM arrives completes the access, so it is not a stall.
    case (state_q)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          state_d = MEMWAIT;
          memwait = 1'b1;
        end
      end
      MEMWAIT: begin
        if (MemReadyM) begin
          state_d = RUN;
        end else begin
          memwait = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushW = 1'b1;
    end else if (memwait) begin
      // Whole pipe frozen; load-use and branch effects wait for the memory.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = ldstall || pcw_busy;
      StallD = ldstall;
      FlushE = ldstall || BranchTakenE;
      FlushD = pcw_busy || PCSrcW || BranchTakenE;
    end

    pcw_inc = PCSrcD && !StallD && !FlushD && !memwait;
    pcw_dec = PCSrcW && !FlushW;

    // Saturate at both ends; illegal cases are flagged by the assertions below.
    if (pcw_inc && !pcw_dec) begin
      if (pcw_cnt_q != CW'(PCW_MAX)) begin
        pcw_cnt_d = pcw_cnt_q + CW'(1);
      end
    end else if (pcw_dec && !pcw_inc) begin
      if (pcw_cnt_q != '0) begin
        pcw_cnt_d = pcw_cnt_q - CW'(1);
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pcw_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pcw_cnt_q <= pcw_cnt_d;
      a_pcw_overflow: assert (!(pcw_inc && !pcw_dec && (pcw_cnt_q == CW'(PCW_MAX))));
      a_pcw_underflow: assert (!(pcw_dec && !pcw_inc && (pcw_cnt_q == '0)));
    end
  end

  assign pcw_pending = pcw_cnt_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_cycles_q;

  // Free-running event counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_cycles_q <= '0;
    end else begin
      if (StallD) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (FlushD || FlushE) begin
        flush_cycles_q <= flush_cycles_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised successor hazard/forwarding controller for the 5-stage (F/D/E/M/W) ARM pipeline.
- Generalises to NSRC source operands per instruction, so Rs of register-shifted-register ops forwards like Rn/Rm.
- Adds a variable-latency data-memory handshake with a MEMWAIT state.
- Replaces the per-stage PCSrc chain with an in-flight PC-write counter.
- Sits beside the datapath; drives stage stall/flush and E-stage operand mux selects.

Parameters:
REG_AW, 4, register-address width (16 architectural registers)
NSRC, 3, source operands tracked per instruction (2..4)
PCW_MAX, 3, max PC-writing instructions in flight D..W; counter width = $clog2(PCW_MAX+1)

Ports:
clk  in  1  clock
reset  in  1  reset
raD  in  NSRC*REG_AW  D-stage source register addresses, operand i at [i*REG_AW +: REG_AW]
raE  in  NSRC*REG_AW  E-stage source register addresses
rdE  in  REG_AW  E-stage destination
RegWriteE  in  1  E writes register
MemtoRegE  in  1  E instruction is a load
rdM  in  REG_AW  M-stage destination
RegWriteM  in  1  M writes register
MemReqM  in  1  M instruction accesses data memory
MemReadyM  in  1  data memory completes access this cycle
rdW  in  REG_AW  W-stage destination
RegWriteW  in  1  W writes register
PCSrcD  in  1  D instruction writes PC (R15)
PCSrcW  in  1  W instruction writes PC this cycle
BranchTakenE  in  1  E branch resolved taken
forwardE  out  NSRC*2  per operand: 00 register file, 01 ResultW, 10 ALUResultM
StallF  out  1  hold PC
StallD  out  1  hold D pipereg
StallE  out  1  hold E pipereg
StallM  out  1  hold M pipereg
FlushD  out  1  bubble into D
FlushE  out  1  bubble into E
FlushW  out  1  bubble into W
pcw_pending  out  $clog2(PCW_MAX+1)  PC writes in flight

Behaviour:
- State machine with two states: RUN and MEMWAIT. Counter pcw_cnt.
- Reset is synchronous: state=RUN, pcw_cnt=0. While reset is high, FlushD=FlushE=FlushW=1, all Stall=0, forwardE=0.
- Forwarding (combinational) for each operand i:
  - 10 if RegWriteM and raE[i]==rdM.
  - else 01 if RegWriteW and raE[i]==rdW.
  - else 00.
  - M has priority over W. Register R15 never forwards.
- ldstall = MemtoRegE and RegWriteE and (raD[i]==rdE for any i < NSRC).
- memwait = state==MEMWAIT, or (state==RUN and MemReqM and !MemReadyM).
- State transitions:
  - RUN to MEMWAIT on MemReqM and !MemReadyM.
  - MEMWAIT to RUN on MemReadyM.
  - The MemReadyM cycle itself is not a stall.
- While memwait:
  - StallF=StallD=StallE=StallM=1, FlushW=1.
  - ldstall and branch effects are deferred. FlushD=FlushE=0.
- Otherwise:
  - StallF = ldstall or pcw_cnt!=0.
  - StallD = ldstall.
  - FlushE = ldstall or BranchTakenE.
  - FlushD = pcw_cnt!=0 or PCSrcW or BranchTakenE.
  - StallE=StallM=FlushW=0.
- Counter:
  - inc = PCSrcD and !StallD and !FlushD and !memwait.
  - dec = PCSrcW and !FlushW.
  - Simultaneous inc and dec leaves the count unchanged.
  - BranchTakenE with a PC-writer in E squashes nothing already counted; the writer still retires.
- Boundaries:
  - inc at pcw_cnt==PCW_MAX saturates and raises an assertion.
  - dec at 0 holds 0 and raises an assertion.
- pcw_pending = pcw_cnt, registered.
- Reset mid-MEMWAIT returns to RUN with pcw_cnt=0 on the next edge.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, adds 32-bit outputs stall_cycles and flush_cycles.
  - stall_cycles increments on any cycle with StallD high.
  - flush_cycles increments on any cycle with FlushD or FlushE high.
  - Both wrap at 2^32 and reset to 0.
- When undefined, these ports do not exist and no counter logic is built.

Decomposition:
- Package pipe_hazard_pkg holds:
  - fwd_sel_e enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - hz_state_e enum (RUN, MEMWAIT).
  - REG_PC constant = 15.
- One sub-module fwd_sel: one operand's comparator and priority logic, instantiated NSRC times via generate.

Test Plan:
- ADD r1 in M, SUB reads r1 as operand 0 in E (RegWriteM=1, rdM=1, raE[0]=1) -> forwardE[1:0]=10. Same with rdW=1 and rdM=2 -> 01. Both rdM=rdW=1 -> 10.
- LDR r3 in E (MemtoRegE=1, rdE=3), D reads raD[2]=3 (Rs) -> StallF=StallD=FlushE=1 for exactly one cycle.
- MemReqM=1 with MemReadyM low for 3 cycles, then high -> Stall F/D/E/M and FlushW high 3 cycles, state back to RUN on the 4th cycle with all stalls 0.
- PCSrcD issues at cycle 0 -> pcw_pending=1 and StallF=FlushD=1 until PCSrcW. After that, pcw_pending=0 and StallF=0 next cycle.
- BranchTakenE while ldstall is asserted -> FlushD=FlushE=1 and StallD=1. Same event during MEMWAIT -> FlushD=FlushE=0 until MemReadyM.
- Assert reset during MEMWAIT with pcw_pending=2 -> next cycle state=RUN, pcw_pending=0, all flushes high while reset is held.
